// File: rtl/commit_serializer_if.sv
// rtl/commit_serializer_if.sv - commit record type and writeback/logger handshake bundle
package commit_serializer_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } commit_data_t;
endpackage

interface commit_serializer_if;
    import commit_serializer_pkg::*;

    logic [1:0]         wb_valid_i;
    commit_data_t [1:0] wb_data_i;
    logic               stall_o;
    logic               log_ready_i;
    logic               commit_valid_o;
    commit_data_t       commit_data_o;

    // master: writeback stage plus logger; slave: the serializer itself
    modport master (
        output wb_valid_i, wb_data_i, log_ready_i,
        input  stall_o, commit_valid_o, commit_data_o
    );
    modport slave (
        input  wb_valid_i, wb_data_i, log_ready_i,
        output stall_o, commit_valid_o, commit_data_o
    );
endinterface

// File: rtl/commit_serializer.sv
// rtl/commit_serializer.sv - dual-lane retire FIFO serialized into a single in-order commit stream
module commit_serializer
    import commit_serializer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    commit_serializer_if.slave       bus,
    input  logic                     end_of_test_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         commits_total_o,
    output logic                     done_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    commit_data_t     mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             stall_q, overflow_q, done_q;
    logic [CNT_W-1:0] total_q;

    logic [1:0]       we;
    logic [PW-1:0]    waddr [2];
    logic [1:0]       n_pushed;
    logic             drop;
    logic             pop;

    // Space is judged against count_q only: a same-cycle pop never frees a slot early.
    always_comb begin
        we       = '0;
        waddr[0] = wptr_q;
        waddr[1] = wptr_q;
        wptr_d   = wptr_q;
        n_pushed = '0;
        drop     = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if (state_q == RUN && bus.wb_valid_i[l]) begin
                if (count_q + CW'(n_pushed) < CW'(DEPTH)) begin
                    we[l]    = 1'b1;
                    waddr[l] = wptr_d;
                    wptr_d   = wptr_d + PW'(1);
                    n_pushed = n_pushed + 2'd1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    assign pop     = bus.commit_valid_o && bus.log_ready_i;
    assign count_d = count_q + CW'(n_pushed) - CW'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (end_of_test_i) state_d = DRAIN;
            DRAIN:   if (count_q == '0 && !pop) state_d = DONE;
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            total_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (we[l]) mem_q[waddr[l]] <= bus.wb_data_i[l];
            end
            if (pop) begin
                rptr_q  <= rptr_q + PW'(1);
                total_q <= total_q + CNT_W'(1);
            end
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_q | drop;
            // Threshold leaves room for one more dual push already in flight upstream.
            stall_q    <= (count_d > CW'(DEPTH - 4)) || (state_d != RUN);
            done_q     <= (state_d == DONE);
        end
    end

    assign bus.commit_valid_o = (count_q != '0) && (state_q != DONE);
    assign bus.commit_data_o  = mem_q[rptr_q];
    assign bus.stall_o        = stall_q;
    assign count_o            = count_q;
    assign overflow_o         = overflow_q;
    assign commits_total_o    = total_q;
    assign done_o             = done_q;
endmodule

// File: doc/commit_serializer.md
Name: commit_serializer

Overview:
- Sits between the dual-lane writeback/graduation stage and the commit logger.
- Buffers up to two retired instructions per cycle in a FIFO and emits them one per cycle, in program order, as a single commit_valid/commit_data stream. That stream drives the logger's commit_valid_i/commit_data_i.
- Provides backpressure, sticky overflow detection, a retired-instruction counter and an end-of-test drain sequence.

Parameters:
- DEPTH, 8: FIFO entries. Must be a power of two and at least 8.
- CNT_W, 64: width of the emitted-commit counter.

Ports:
- clk, input, 1: core clock.
- rst, input, 1: asynchronous reset, active-low.
- wb_valid_i, input, 2: per-lane commit valid. Lane 0 is older than lane 1.
- wb_data_i, input, 2 x $bits(commit_data_t): per-lane commit record (commit_data_t).
- log_ready_i, input, 1: consumer accepts the output this cycle. Tie to 1 for the behavioural logger.
- end_of_test_i, input, 1: pulse; requests drain and shutdown.
- stall_o, output, 1: tells the upstream stage to stop retiring.
- commit_valid_o, output, 1: head entry valid.
- commit_data_o, output, $bits(commit_data_t): head entry record.
- count_o, output, $clog2(DEPTH)+1: current occupancy.
- overflow_o, output, 1: sticky; a commit was dropped.
- commits_total_o, output, CNT_W: number of records handed off.
- done_o, output, 1: drain complete. Sticky.

Behaviour:
- **Reset (rst=0, async):**
  - Read/write pointers and count are 0.
  - FSM is in RUN.
  - commit_valid_o, stall_o, overflow_o and done_o are 0.
  - commits_total_o is 0.
  - commit_data_o is 0.
  - Reset mid-operation discards all buffered entries. No output is emitted until the first push after reset release.
- **Storage:** circular buffer of DEPTH entries. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count_q tracks occupancy separately, so full (DEPTH) and empty (0) are unambiguous.
- **Push:**
  - n_push = popcount(wb_valid_i), accepted only in RUN.
  - Valid lanes are written in lane order (lane 0 first) at consecutive wptr slots.
  - wb_valid_i=2'b10 writes lane 1 alone at wptr.
- **Pop:** pop occurs when commit_valid_o && log_ready_i.
- **Latency:** an entry pushed in cycle t appears on commit_data_o no earlier than cycle t+1. Output is registered storage read at rptr, with no input-to-output combinational path.
- **commit_valid_o:** equals (count_q != 0).
  - commit_data_o must hold stable while commit_valid_o=1 and log_ready_i=0.
- **Space check:**
  - Uses count_q before the same-cycle pop; a pop does not credit space in the same cycle.
  - If count_q + n_push > DEPTH, lanes are written in order while space remains and the rest are dropped.
  - Any drop sets overflow_o on the next edge. It stays set until reset.
- **Simultaneous push and pop:** count_d = count_q + pushed − popped.
- **stall_o:** 1 when count_q > DEPTH−4, or when FSM != RUN. This leaves one cycle of in-flight dual pushes of slack.
- **commits_total_o:** increments by 1 on every pop. Wraps at 2^CNT_W.
- **FSM:**
  - RUN → DRAIN when end_of_test_i=1.
  - In DRAIN, pushes are ignored without setting overflow; pops continue.
  - DRAIN → DONE when count_q==0 and there is no pop in flight.
  - In DONE: done_o=1, commit_valid_o=0, inputs are ignored. Exit is by reset only.
  - end_of_test_i in DRAIN or DONE has no effect.
  - If end_of_test_i arrives in the same cycle as a push, that cycle's push is still accepted (RUN is in effect).

Test Plan:
1. Reset, then wb_valid_i=2'b11 with PCs 0x100/0x104 for one cycle, log_ready_i=1 → commit_valid_o high for cycles t+1 and t+2 with PCs 0x100 then 0x104; commits_total_o=2; count_o returns to 0.
2. log_ready_i=0, push 2 per cycle for 3 cycles → count_o=6; stall_o rises once count_o>4 (DEPTH=8); commit_data_o holds 1st PC; overflow_o stays 0.
3. log_ready_i=0, count at 7, push 2'b11 → lane 0 stored, lane 1 dropped; count_o=8; overflow_o=1 next cycle and sticky thereafter.
4. Wrap: 20 single pushes interleaved with pops, log_ready_i random → output PC sequence identical to input order; commits_total_o=20; no overflow.
5. Buffer holding 3 entries, pulse end_of_test_i with log_ready_i=1 → stall_o=1 immediately; further wb_valid_i ignored; 3 pops; done_o=1 the cycle after count_o reaches 0.
6. Assert rst low asynchronously with 5 entries buffered → all outputs 0 within the same cycle; after release, no stale commit_valid_o.
